// File: rtl/ls_ex_queue_if.sv
// Opcode/flag encodings plus the bundled LSB, memctrl and CDB signals of the
// load/store execute queue.
package ls_ex_pkg;
  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;
  localparam logic FLAG_READ  = 1'b0;
  localparam logic FLAG_WRITE = 1'b1;
endpackage

interface ls_ex_queue_if #(
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32,
  parameter int TAG_LEN    = 4,
  parameter int OPENUM_LEN = 6
);
  logic                  in_valid;
  logic [OPENUM_LEN-1:0] in_openum;
  logic [ADDR_LEN-1:0]   in_addr;
  logic [DATA_LEN-1:0]   in_store_value;
  logic [TAG_LEN-1:0]    in_tag;
  logic                  busy_to_lsb;
  logic                  ena_to_mc;
  logic [ADDR_LEN-1:0]   addr_to_mc;
  logic [DATA_LEN-1:0]   data_to_mc;
  logic                  wr_flag_to_mc;
  logic [2:0]            size_to_mc;
  logic                  ok_flag_from_mc;
  logic [DATA_LEN-1:0]   data_from_mc;
  logic                  valid;
  logic [DATA_LEN-1:0]   result;
  logic [TAG_LEN-1:0]    result_tag;
  logic                  result_is_store;

  modport slave (
    input  in_valid, in_openum, in_addr, in_store_value, in_tag,
    input  ok_flag_from_mc, data_from_mc,
    output busy_to_lsb, ena_to_mc, addr_to_mc, data_to_mc, wr_flag_to_mc, size_to_mc,
    output valid, result, result_tag, result_is_store
  );

  modport master (
    output in_valid, in_openum, in_addr, in_store_value, in_tag,
    output ok_flag_from_mc, data_from_mc,
    input  busy_to_lsb, ena_to_mc, addr_to_mc, data_to_mc, wr_flag_to_mc, size_to_mc,
    input  valid, result, result_tag, result_is_store
  );
endinterface

// File: rtl/ls_ex_queue.sv
// In-order load/store execute queue: buffers LSB ops, runs one memctrl access
// at a time and broadcasts extended load data / store completions on the CDB.
//
// state  | meaning
// IDLE   | no access outstanding; pops the FIFO head when non-empty
// WAIT   | access presented to memctrl, waiting for its ok pulse
module ls_ex_queue
  import ls_ex_pkg::*;
#(
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_LEN    = 4,
  parameter int OPENUM_LEN = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  ls_ex_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  typedef struct packed {
    logic [OPENUM_LEN-1:0] op;
    logic [ADDR_LEN-1:0]   addr;
    logic [DATA_LEN-1:0]   data;
    logic [TAG_LEN-1:0]    tag;
  } entry_t;

  function automatic logic is_op(input logic [OPENUM_LEN-1:0] op, input logic [5:0] code);
    return op == OPENUM_LEN'(code);
  endfunction

  function automatic logic is_store(input logic [OPENUM_LEN-1:0] op);
    return is_op(op, OP_SB) || is_op(op, OP_SH) || is_op(op, OP_SW);
  endfunction

  function automatic logic is_load(input logic [OPENUM_LEN-1:0] op);
    return is_op(op, OP_LB) || is_op(op, OP_LH) || is_op(op, OP_LW) ||
           is_op(op, OP_LBU) || is_op(op, OP_LHU);
  endfunction

  function automatic logic [2:0] size_of(input logic [OPENUM_LEN-1:0] op);
    if (is_op(op, OP_LB) || is_op(op, OP_LBU) || is_op(op, OP_SB)) return 3'd1;
    if (is_op(op, OP_LH) || is_op(op, OP_LHU) || is_op(op, OP_SH)) return 3'd2;
    return 3'd4;
  endfunction

  function automatic logic [DATA_LEN-1:0] extend(input logic [OPENUM_LEN-1:0] op,
                                                 input logic [DATA_LEN-1:0]   d);
    logic [DATA_LEN-1:0] r;
    r = d;
    if (is_op(op, OP_LB))       r = {{(DATA_LEN-8){d[7]}}, d[7:0]};
    else if (is_op(op, OP_LBU)) r = {{(DATA_LEN-8){1'b0}}, d[7:0]};
    else if (is_op(op, OP_LH))  r = {{(DATA_LEN-16){d[15]}}, d[15:0]};
    else if (is_op(op, OP_LHU)) r = {{(DATA_LEN-16){1'b0}}, d[15:0]};
    return r;
  endfunction

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  state_e                state_q, state_d;
  logic                  ena_q, ena_d, wr_q, wr_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [DATA_LEN-1:0]   data_q, data_d;
  logic [2:0]            size_q, size_d;
  logic [OPENUM_LEN-1:0] cur_op_q, cur_op_d;
  logic [TAG_LEN-1:0]    cur_tag_q, cur_tag_d;
  logic                  killed_q, killed_d;
  logic                  valid_q, valid_d;
  logic [DATA_LEN-1:0]   result_q, result_d;
  logic [TAG_LEN-1:0]    res_tag_q, res_tag_d;
  logic                  res_store_q, res_store_d;
  logic                  busy, push, pop;
  entry_t                head;

  assign busy = (count_q == (PTR_W+1)'(DEPTH));
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    ena_d       = ena_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    size_d      = size_q;
    cur_op_d    = cur_op_q;
    cur_tag_d   = cur_tag_q;
    killed_d    = killed_q;
    valid_d     = 1'b0;
    result_d    = result_q;
    res_tag_d   = res_tag_q;
    res_store_d = res_store_q;
    pop         = 1'b0;
    push        = bus.in_valid && !busy && !flush &&
                  (is_load(bus.in_openum) || is_store(bus.in_openum));

    if (push) begin
      mem_d[wr_ptr_q] = '{op: bus.in_openum, addr: bus.in_addr,
                          data: bus.in_store_value, tag: bus.in_tag};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !flush) begin
          pop       = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          state_d   = S_WAIT;
          ena_d     = 1'b1;
          addr_d    = head.addr;
          data_d    = is_store(head.op) ? head.data : '0;
          wr_d      = is_store(head.op) ? FLAG_WRITE : FLAG_READ;
          size_d    = size_of(head.op);
          cur_op_d  = head.op;
          cur_tag_d = head.tag;
          killed_d  = 1'b0;
        end
      end
      S_WAIT: begin
        // A flush cannot abort the memctrl access, it only suppresses the completion.
        if (flush) killed_d = 1'b1;
        if (bus.ok_flag_from_mc) begin
          ena_d   = 1'b0;
          state_d = S_IDLE;
          if (!killed_q && !flush) begin
            valid_d     = 1'b1;
            result_d    = is_store(cur_op_q) ? '0 : extend(cur_op_q, bus.data_from_mc);
            res_tag_d   = cur_tag_q;
            res_store_d = is_store(cur_op_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      ena_q       <= 1'b0;
      wr_q        <= FLAG_READ;
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= '0;
      cur_op_q    <= '0;
      cur_tag_q   <= '0;
      killed_q    <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      res_tag_q   <= '0;
      res_store_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      ena_q       <= ena_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      size_q      <= size_d;
      cur_op_q    <= cur_op_d;
      cur_tag_q   <= cur_tag_d;
      killed_q    <= killed_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      res_tag_q   <= res_tag_d;
      res_store_q <= res_store_d;
    end
  end

  assign bus.busy_to_lsb     = busy;
  assign bus.ena_to_mc       = ena_q;
  assign bus.addr_to_mc      = addr_q;
  assign bus.data_to_mc      = data_q;
  assign bus.wr_flag_to_mc   = wr_q;
  assign bus.size_to_mc      = size_q;
  assign bus.valid           = valid_q;
  assign bus.result          = result_q;
  assign bus.result_tag      = res_tag_q;
  assign bus.result_is_store = res_store_q;
endmodule

// File: tb/tb_ls_ex_queue.sv
// Scoreboard bench for ls_ex_queue: a queue-level model predicts memctrl requests
// and CDB completions; a monitor pops and compares them as the DUT presents them.
module tb_ls_ex_queue;
  import ls_ex_pkg::*;
  localparam int DEPTH = 4;

  typedef struct { logic [5:0] op; logic [31:0] addr; logic [31:0] data; logic [3:0] tag; } op_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [2:0] size; logic wr; } req_t;
  typedef struct { logic [31:0] result; logic [3:0] tag; logic st; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ls_ex_queue_if bus();
  ls_ex_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  op_t  mq[$];
  req_t exp_req[$];
  res_t exp_res[$];
  op_t  cur;
  req_t mon_req;
  bit   in_fl, killed, exp_valid, stall, use_fix, ena_prev;
  int   lat, fixed_lat;
  logic [31:0] fix_data, mc_data;
  int   errors = 0;
  int   checks = 0;

  function automatic bit op_is_store(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit op_is_mem(input logic [5:0] op);
    return op >= OP_LB && op <= OP_SW;
  endfunction

  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 3'd1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 3'd2;
    return 3'd4;
  endfunction

  // Extension expressed as integer arithmetic on the low byte/half.
  function automatic logic [31:0] load_value(input logic [5:0] op, input logic [31:0] d);
    int b, h;
    b = int'(d & 32'hFF);
    h = int'(d & 32'hFFFF);
    case (op)
      OP_LB:   return 32'((b >= 128) ? b - 256 : b);
      OP_LBU:  return 32'(b);
      OP_LH:   return 32'((h >= 32768) ? h - 65536 : h);
      OP_LHU:  return 32'(h);
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check level outputs, drive inputs + memctrl reply, update model.
  task automatic step(input bit v, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] sv, input logic [3:0] tag, input bit fl,
                      input bit stray_ok);
    bit ok_now, was_fl, accept;
    int n;
    @(negedge clk);
    chk("busy_to_lsb", 32'(bus.busy_to_lsb), 32'(mq.size() == DEPTH));
    chk("ena_to_mc", 32'(bus.ena_to_mc), 32'(in_fl));
    chk("valid", 32'(bus.valid), 32'(exp_valid));
    bus.in_valid = v; bus.in_openum = op; bus.in_addr = addr;
    bus.in_store_value = sv; bus.in_tag = tag; flush = fl;
    ok_now = 1'b0;
    if (in_fl && !stall && lat == 0) begin
      ok_now = 1'b1;
      mc_data = use_fix ? fix_data : $urandom;
      bus.data_from_mc = mc_data;
    end else if (!in_fl && stray_ok) begin
      ok_now = 1'b1;
      bus.data_from_mc = $urandom;
    end else if (in_fl && !stall) begin
      lat--;
    end
    bus.ok_flag_from_mc = ok_now;
    @(posedge clk);
    exp_valid = 1'b0;
    n = mq.size();
    was_fl = in_fl;
    accept = v && op_is_mem(op) && !fl && n < DEPTH;
    if (in_fl && fl) killed = 1'b1;
    if (in_fl && ok_now) begin
      in_fl = 1'b0;
      if (!killed) begin
        exp_valid = 1'b1;
        exp_res.push_back('{op_is_store(cur.op) ? 32'h0 : load_value(cur.op, mc_data),
                            cur.tag, op_is_store(cur.op)});
      end
    end
    if (fl) mq.delete();
    else begin
      if (!was_fl && n > 0) begin
        cur = mq.pop_front();
        in_fl = 1'b1;
        killed = 1'b0;
        lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
        exp_req.push_back('{cur.addr, cur.data, op_bytes(cur.op), op_is_store(cur.op)});
      end
      if (accept) mq.push_back('{op, addr, sv, tag});
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, OP_NOP, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  // Monitor: consumes expected requests and completions as the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ena_to_mc && !ena_prev) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request: got addr %h expected none", bus.addr_to_mc);
        end else begin
          mon_req = exp_req.pop_front();
          chk("req_addr", bus.addr_to_mc, mon_req.addr);
          chk("req_size", 32'(bus.size_to_mc), 32'(mon_req.size));
          chk("req_wr_flag", 32'(bus.wr_flag_to_mc), 32'(mon_req.wr));
          if (mon_req.wr) chk("req_data", bus.data_to_mc, mon_req.data);
        end
      end else if (bus.ena_to_mc) begin
        chk("req_addr_stable", bus.addr_to_mc, mon_req.addr);
      end
      if (bus.valid) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got tag %h expected none", bus.result_tag);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("result", bus.result, r.result);
          chk("result_tag", 32'(bus.result_tag), 32'(r.tag));
          chk("result_is_store", 32'(bus.result_is_store), 32'(r.st));
        end
      end
    end
    ena_prev = rst && bus.ena_to_mc;
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_openum = '0; bus.in_addr = '0; bus.in_store_value = '0;
    bus.in_tag = '0; bus.ok_flag_from_mc = 1'b0; bus.data_from_mc = '0;
    in_fl = 0; killed = 0; exp_valid = 0; stall = 0; use_fix = 0; ena_prev = 0;
    lat = 0; fixed_lat = -1; fix_data = '0; mc_data = '0;

    #12;
    chk("rst_ena", 32'(bus.ena_to_mc), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_tag", 32'(bus.result_tag), 32'h0);
    chk("rst_is_store", 32'(bus.result_is_store), 32'h0);
    chk("rst_addr", bus.addr_to_mc, 32'h0);
    chk("rst_data", bus.data_to_mc, 32'h0);
    chk("rst_size", 32'(bus.size_to_mc), 32'h0);
    chk("rst_wr_flag", 32'(bus.wr_flag_to_mc), 32'(FLAG_READ));
    chk("rst_busy", 32'(bus.busy_to_lsb), 32'h0);
    @(negedge clk); rst = 1'b1;

    // LB sign extension, fixed 3-cycle memctrl latency
    fixed_lat = 3; use_fix = 1; fix_data = 32'h0000_00F0;
    step(1'b1, OP_LB, 32'h100, 32'h0, 4'h5, 1'b0, 1'b0);
    idle(8);
    // LHU zero extension
    fix_data = 32'h0000_8001;
    step(1'b1, OP_LHU, 32'h102, 32'h0, 4'h6, 1'b0, 1'b0);
    idle(8);
    // store then load to same address, order kept
    use_fix = 0; fixed_lat = 1;
    step(1'b1, OP_SW, 32'h200, 32'hDEAD_BEEF, 4'h7, 1'b0, 1'b0);
    step(1'b1, OP_LW, 32'h200, 32'h0, 4'h8, 1'b0, 1'b0);
    idle(10);
    // fill with memctrl stalled; extra pushes while full are refused
    stall = 1;
    for (int i = 0; i < 7; i++)
      step(1'b1, (i % 2) ? OP_SH : OP_LH, 32'h300 + 32'(i * 2), $urandom, 4'(i), 1'b0, 1'b0);
    idle(3);
    stall = 0;
    idle(30);
    // flush while a load is in WAIT with two ops queued
    stall = 1;
    step(1'b1, OP_LW, 32'h400, 32'h0, 4'h9, 1'b0, 1'b0);
    step(1'b1, OP_LB, 32'h404, 32'h0, 4'hA, 1'b0, 1'b0);
    step(1'b1, OP_SB, 32'h408, 32'h55, 4'hB, 1'b0, 1'b0);
    idle(2);
    step(1'b1, OP_SW, 32'h40C, 32'h1, 4'hC, 1'b1, 1'b0);
    idle(3);
    stall = 0;
    idle(10);
    // asynchronous reset in the middle of an access
    stall = 1;
    step(1'b1, OP_LW, 32'h500, 32'h0, 4'hD, 1'b0, 1'b0);
    idle(3);
    #2 rst = 1'b0;
    #1 chk("async_rst_ena", 32'(bus.ena_to_mc), 32'h0);
    chk("async_rst_valid", 32'(bus.valid), 32'h0);
    bus.in_valid = 1'b0; bus.ok_flag_from_mc = 1'b0; flush = 1'b0;
    mq.delete(); in_fl = 0; killed = 0; exp_valid = 0; stall = 0;
    @(negedge clk); rst = 1'b1;
    idle(6);
    // randomized traffic, including NOP/unknown opcodes, flushes and stray oks
    fixed_lat = -1;
    for (int i = 0; i < 600; i++) begin
      logic [5:0] rop;
      rop = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(9, 63)) : 6'($urandom_range(0, 8));
      step(($urandom_range(0, 2) != 0), rop, $urandom, $urandom, 4'($urandom),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(40);
    chk("drain_requests", 32'(exp_req.size()), 32'h0);
    chk("drain_results", 32'(exp_res.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
